// File: rtl/rca_seq_ctrl.sv
// Add/subtract sequencer that drives one shared external 4-bit ripple-carry adder.
// It processes one nibble per clock, LSB first, and carries between nibbles in carry_r.
module rca_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic [3:0]             rca_a,
  output logic [3:0]             rca_b,
  output logic                   rca_cin,
  input  logic [3:0]             rca_s,
  input  logic                   rca_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_r, b_r, result_r;
  logic            carry_r, cout_r, ovf_r;
  logic [KW-1:0]   k;
  logic [KW+1:0]   base;
  logic            accept;

  assign base   = {k, 2'b00};
  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    rca_a    = 4'd0;
    rca_b    = 4'd0;
    rca_cin  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        rca_a   = a_r[base +: 4];
        rca_b   = b_r[base +: 4];
        rca_cin = carry_r;
        if (k == K_LAST) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: b is inverted on capture and the +1 enters as the initial carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      carry_r  <= 1'b0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      k        <= '0;
    end else if (accept) begin
      a_r      <= a;
      b_r      <= op_sub ? ~b : b;
      carry_r  <= op_sub;
      k        <= '0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (state == RUN) begin
      result_r[base +: 4] <= rca_s;
      carry_r             <= rca_cout;
      k                   <= k + 1'b1;
      if (k == K_LAST) begin
        // The top result bit is still arriving from the adder on this edge, so take it from rca_s.
        cout_r <= rca_cout;
        ovf_r  <= (a_r[W-1] == b_r[W-1]) && (rca_s[3] != a_r[W-1]);
        k      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl with a behavioural 4-bit adder on the rca_* ports and a queue of expected results.
module tb_rca_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic [3:0]   cins;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;
  logic [3:0]   rca_a, rca_b, rca_s;
  logic         rca_cin, rca_cout;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  bit   cin_q[$];
  exp_t exp_q[$];

  rca_seq_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin), .rca_s(rca_s), .rca_cout(rca_cout)
  );

  // External shared adder
  assign {rca_cout, rca_s} = {1'b0, rca_a} + {1'b0, rca_b} + {4'd0, rca_cin};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy && !done) cin_q.push_back(rca_cin);
  end

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    logic [W:0] full;
    exp_t e;
    if (sub) full = {1'b0, x} - {1'b0, y};
    else     full = {1'b0, x} + {1'b0, y};
    e.r = full[W-1:0];
    e.c = sub ? (x >= y) : full[W];
    e.v = sub ? ((x[W-1] != y[W-1]) && (e.r[W-1] != x[W-1]))
              : ((x[W-1] == y[W-1]) && (e.r[W-1] != x[W-1]));
    return e;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Issues one operation and waits (bounded) for done; n is the number of edges until done is seen.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub, output int n);
    cin_q.delete();
    a = ia; b = ib; op_sub = isub; start = 1'b1; n = 0;
    do begin
      tick();
      n++;
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
    end while (!done && n < 20);
  endtask

  task automatic test_reset;
    start = 1'b1;
    #12;
    checks++;
    if ({busy, done, result, cout, ovf, rca_a, rca_b, rca_cin} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b result=%h cout=%b ovf=%b rca_a=%h rca_b=%h rca_cin=%b, required all 0",
               busy, done, result, cout, ovf, rca_a, rca_b, rca_cin);
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_arith;
    vec_t  tbl[5];
    exp_t  e;
    int    n;
    logic [3:0] got;
    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{tbl[i].r, tbl[i].c, tbl[i].v});
      launch(tbl[i].a, tbl[i].b, tbl[i].sub, n);
      e = exp_q.pop_front();
      checks++;
      if (n !== N + 1) begin
        errors++;
        $display("FAIL arith%0d_latency: done after %0d edges, required %0d", i, n, N + 1);
      end
      checks++;
      if ({result, cout, ovf} !== {e.r, e.c, e.v}) begin
        errors++;
        $display("FAIL arith%0d_result: result=%h cout=%b ovf=%b, required %h %b %b",
                 i, result, cout, ovf, e.r, e.c, e.v);
      end
      got = 4'hx;
      if (cin_q.size() == 4) got = {cin_q[3], cin_q[2], cin_q[1], cin_q[0]};
      checks++;
      if (got !== tbl[i].cins) begin
        errors++;
        $display("FAIL arith%0d_rca_cin: sequence %b (%0d samples), required %b", i, got, cin_q.size(), tbl[i].cins);
      end
      tick();
      checks++;
      if ({done, busy, rca_a, rca_b, rca_cin, result, cout, ovf} !== {2'b00, 9'd0, e.r, e.c, e.v}) begin
        errors++;
        $display("FAIL arith%0d_hold: done=%b busy=%b rca=%h/%h/%b result=%h cout=%b ovf=%b, required 0 0 0/0/0 %h %b %b",
                 i, done, busy, rca_a, rca_b, rca_cin, result, cout, ovf, e.r, e.c, e.v);
      end
    end
  endtask

  task automatic test_random;
    exp_t e;
    int   n;
    logic [W-1:0] x, y;
    logic s;
    for (int i = 0; i < 8; i++) begin
      x = W'($urandom); y = W'($urandom); s = 1'($urandom);
      exp_q.push_back(model(x, y, s));
      launch(x, y, s, n);
      e = exp_q.pop_front();
      checks++;
      if (n !== N + 1 || {result, cout, ovf} !== {e.r, e.c, e.v}) begin
        errors++;
        $display("FAIL random%0d: %h %s %h -> result=%h cout=%b ovf=%b after %0d edges, required %h %b %b after %0d",
                 i, x, s ? "-" : "+", y, result, cout, ovf, n, e.r, e.c, e.v, N + 1);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start;
    exp_t e;
    int   n, d0;
    d0 = done_cnt;
    exp_q.push_back('{16'h1234, 1'b0, 1'b0});
    a = 16'h1000; b = 16'h0234; op_sub = 1'b0; start = 1'b1; n = 0;
    do begin
      tick();
      n++;
      a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
    end while (!done && n < 20);
    e = exp_q.pop_front();
    checks++;
    if (n !== N + 1 || {result, cout, ovf} !== {e.r, e.c, e.v}) begin
      errors++;
      $display("FAIL ignore_result: result=%h cout=%b ovf=%b after %0d edges, required %h %b %b after %0d",
               result, cout, ovf, n, e.r, e.c, e.v, N + 1);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: busy=%b, required 0", busy);
    end
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (done_cnt !== d0 + 1 || busy !== 1'b0 || result !== e.r) begin
      errors++;
      $display("FAIL ignore_single_done: done pulses=%0d busy=%b result=%h, required 1 0 %h",
               done_cnt - d0, busy, result, e.r);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   n1, n2;
    exp_q.push_back(model(16'h0F0F, 16'h0101, 1'b0));
    exp_q.push_back(model(16'h9000, 16'h1000, 1'b1));
    a = 16'h0F0F; b = 16'h0101; op_sub = 1'b0; start = 1'b1;
    tick();
    a = 16'h9000; b = 16'h1000; op_sub = 1'b1;
    n1 = 1;
    while (!done && n1 < 20) begin
      tick();
      n1++;
    end
    e = exp_q.pop_front();
    checks++;
    if (n1 !== N + 1 || {result, cout, ovf} !== {e.r, e.c, e.v}) begin
      errors++;
      $display("FAIL b2b_first: result=%h cout=%b ovf=%b after %0d edges, required %h %b %b after %0d",
               result, cout, ovf, n1, e.r, e.c, e.v, N + 1);
    end
    n2 = 0;
    do begin
      tick();
      n2++;
      if (busy && !done) start = 1'b0;
    end while (!done && n2 < 20);
    start = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (n2 !== N + 2) begin
      errors++;
      $display("FAIL b2b_throughput: %0d cycles between done pulses, required %0d", n2, N + 2);
    end
    checks++;
    if ({result, cout, ovf} !== {e.r, e.c, e.v}) begin
      errors++;
      $display("FAIL b2b_second: result=%h cout=%b ovf=%b, required %h %b %b", result, cout, ovf, e.r, e.c, e.v);
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    exp_t e;
    int   n, d0;
    a = 16'h1234; b = 16'h1111; op_sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, result} !== {1'b1, 16'h0045}) begin
      errors++;
      $display("FAIL midrun_partial: busy=%b result=%h, required 1 0045", busy, result);
    end
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, result, cout, ovf, rca_a, rca_b, rca_cin} !== '0) begin
      errors++;
      $display("FAIL midrun_async_reset: busy=%b done=%b result=%h cout=%b ovf=%b rca=%h/%h/%b, required all 0",
               busy, done, result, cout, ovf, rca_a, rca_b, rca_cin);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: done pulses=%0d busy=%b, required 0 0", done_cnt - d0, busy);
    end
    exp_q.push_back('{16'h0100, 1'b0, 1'b0});
    launch(16'h00FF, 16'h0001, 1'b0, n);
    e = exp_q.pop_front();
    checks++;
    if (n !== N + 1 || {result, cout, ovf} !== {e.r, e.c, e.v}) begin
      errors++;
      $display("FAIL midrun_after_reset: result=%h cout=%b ovf=%b after %0d edges, required %h %b %b after %0d",
               result, cout, ovf, n, e.r, e.c, e.v, N + 1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
